// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver with an internal baud counter.
// The serial line is double-flopped, the start bit is re-checked at
// mid-bit, data bits are sampled LSB-first at mid-bit and the stop bit
// is validated before a byte is handed to the register interface.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_rx_clear,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_flag,
  output logic       o_frame_error,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] TC_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHECK,
    RECEIVE_DATA,
    STOP_BIT,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level so a
  // reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with baud counter, shifter, strobes and sticky flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_rx_flag     <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_frame_error <= 1'b0;

      if (i_rx_clear) begin
        o_rx_flag <= 1'b0;
        o_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state  <= START_CHECK;
            o_busy <= 1'b1;
          end
        end

        START_CHECK: begin
          if (cnt == TC_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= RECEIVE_DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RECEIVE_DATA: begin
          if (cnt == TC_FULL) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP_BIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP_BIT: begin
          if (cnt == TC_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              o_rx_data  <= shift_reg;
              o_rx_valid <= 1'b1;
              o_rx_flag  <= 1'b1;
              if (o_rx_flag && !i_rx_clear) begin
                o_overrun <= 1'b1;
              end
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_idx <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: bench for the UART receiver at 16 clocks per bit.
// Table-driven frames, hand-written corner sequences and randomised
// frames checked against a byte-level model of the flag rules.
module tb_uart_rx_fsm;

  localparam int CPB = 16;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic       i_rx_clear;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_flag;
  logic       o_frame_error;
  logic       o_overrun;
  logic       o_busy;

  int checks;
  int failures;
  int valid_cnt;
  int fe_cnt;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_flag;
    logic       exp_ovr;
    int         exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] m_data;
  logic       m_flag;
  logic       m_ovr;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .i_rx_clear   (i_rx_clear),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_rx_flag    (o_rx_flag),
    .o_frame_error(o_frame_error),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  // Free-running system clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count strobe cycles on the inactive edge; a stuck strobe counts twice.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_rx_valid) valid_cnt++;
      if (o_frame_error) fe_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one serial frame starting on the current negedge.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit, input int extra_low);
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_rx = stop_bit;
    repeat (CPB) @(negedge i_clk);
    if (extra_low > 0) begin
      i_rx = 1'b0;
      repeat (extra_low) @(negedge i_clk);
    end
    i_rx = 1'b1;
  endtask

  task automatic pulseClear();
    i_rx_clear = 1'b1;
    @(negedge i_clk);
    i_rx_clear = 1'b0;
  endtask

  initial begin
    int v0;
    int f0;
    checks     = 0;
    failures   = 0;
    valid_cnt  = 0;
    fe_cnt     = 0;
    i_rst      = 1'b1;
    i_rx       = 1'b1;
    i_rx_clear = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1, 0};
    vecs[6] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1, 0};

    repeat (3) @(negedge i_clk);
    checkOutput("reset_outputs",
                {o_rx_data, o_rx_valid, o_rx_flag, o_frame_error, o_overrun, o_busy}, 32'h0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // Short low glitch must be rejected at the half-bit check.
    v0 = valid_cnt; f0 = fe_cnt;
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (30) @(negedge i_clk);
    checkOutput("glitch_valid", valid_cnt - v0, 0);
    checkOutput("glitch_fe", fe_cnt - f0, 0);
    checkOutput("glitch_flag", o_rx_flag, 0);
    checkOutput("glitch_busy", o_busy, 0);

    // Table of frames with expected register state after each.
    for (int r = 0; r < 7; r++) begin
      if (vecs[r].clr) pulseClear();
      v0 = valid_cnt; f0 = fe_cnt;
      applyStimulus(vecs[r].data, vecs[r].stop, 0);
      repeat (8) @(negedge i_clk);
      checkOutput($sformatf("vec%0d_data", r), o_rx_data, vecs[r].exp_data);
      checkOutput($sformatf("vec%0d_flag", r), o_rx_flag, vecs[r].exp_flag);
      checkOutput($sformatf("vec%0d_ovr", r), o_overrun, vecs[r].exp_ovr);
      checkOutput($sformatf("vec%0d_valid", r), valid_cnt - v0, vecs[r].exp_valid);
      checkOutput($sformatf("vec%0d_fe", r), fe_cnt - f0, vecs[r].exp_fe);
      checkOutput($sformatf("vec%0d_busy", r), o_busy, 0);
    end

    pulseClear();
    @(negedge i_clk);
    checkOutput("clear_flag", o_rx_flag, 0);
    checkOutput("clear_ovr", o_overrun, 0);
    checkOutput("clear_data_held", o_rx_data, 8'h22);

    // Framing error followed by a long break, then a good byte.
    v0 = valid_cnt; f0 = fe_cnt;
    applyStimulus(8'h3C, 1'b0, 40);
    repeat (20) @(negedge i_clk);
    checkOutput("break_fe", fe_cnt - f0, 1);
    checkOutput("break_no_bytes", valid_cnt - v0, 0);
    checkOutput("break_flag", o_rx_flag, 0);
    applyStimulus(8'h81, 1'b1, 0);
    repeat (8) @(negedge i_clk);
    checkOutput("after_break_valid", valid_cnt - v0, 1);
    checkOutput("after_break_data", o_rx_data, 8'h81);
    checkOutput("after_break_flag", o_rx_flag, 1);

    // Clear pulse lands on the stop-sample edge (155 edges after start).
    fork
      applyStimulus(8'h5A, 1'b1, 0);
      begin
        repeat (154) @(negedge i_clk);
        i_rx_clear = 1'b1;
        @(negedge i_clk);
        i_rx_clear = 1'b0;
      end
    join
    repeat (8) @(negedge i_clk);
    checkOutput("setwins_flag", o_rx_flag, 1);
    checkOutput("setwins_ovr", o_overrun, 0);
    checkOutput("setwins_data", o_rx_data, 8'h5A);

    // Asynchronous reset in the middle of a byte.
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = i[0];
      repeat (CPB) @(negedge i_clk);
    end
    repeat (5) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("midreset_async",
                {o_rx_data, o_rx_valid, o_rx_flag, o_frame_error, o_overrun, o_busy}, 32'h0);
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    checkOutput("midreset_held",
                {o_rx_data, o_rx_valid, o_rx_flag, o_frame_error, o_overrun, o_busy}, 32'h0);
    i_rst = 1'b0;
    repeat (40) @(negedge i_clk);
    checkOutput("midreset_no_strobe", {o_rx_valid, o_frame_error, o_busy}, 0);
    v0 = valid_cnt; f0 = fe_cnt;
    applyStimulus(8'hF0, 1'b1, 0);
    repeat (8) @(negedge i_clk);
    checkOutput("postreset_data", o_rx_data, 8'hF0);
    checkOutput("postreset_valid", valid_cnt - v0, 1);
    checkOutput("postreset_flag", o_rx_flag, 1);
    checkOutput("postreset_ovr", o_overrun, 0);

    // Randomised frames against a byte-level model of the flag rules.
    m_data = 8'hF0;
    m_flag = 1'b1;
    m_ovr  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       stop;
      int         exp_v;
      int         exp_f;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) begin
        pulseClear();
        m_flag = 1'b0;
        m_ovr  = 1'b0;
      end
      v0 = valid_cnt; f0 = fe_cnt;
      applyStimulus(d, stop, 0);
      if (stop) begin
        if (m_flag) m_ovr = 1'b1;
        m_flag = 1'b1;
        m_data = d;
        exp_v  = 1;
        exp_f  = 0;
      end else begin
        exp_v = 0;
        exp_f = 1;
      end
      repeat ($urandom_range(4, 20)) @(negedge i_clk);
      checkOutput($sformatf("rnd%0d_data", n), o_rx_data, m_data);
      checkOutput($sformatf("rnd%0d_flag", n), o_rx_flag, m_flag);
      checkOutput($sformatf("rnd%0d_ovr", n), o_overrun, m_ovr);
      checkOutput($sformatf("rnd%0d_valid", n), valid_cnt - v0, exp_v);
      checkOutput($sformatf("rnd%0d_fe", n), fe_cnt - f0, exp_f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
